lcd_status_reader: RTL and testbench

Read-side companion to the team's HD44780 LCD write driver. It runs instruction-register read cycles (RS=0, RW=1) on the shared LCD bus and returns the busy flag and address counter. It can optionally keep polling until the controller reports ready or a poll limit is reached. It sits beside the LCD driver in the top level; the top level multiplexes the LCD pins to this block while `bus_own`=1 and tristates `lcd_DB` during that time.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_phase_timer.sv | 48 ++++
 rtl/lcd_status_reader.sv | 166 ++++++++++++++++
 tb/tb_lcd_status_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared HD44780 bus timing defaults and status-read state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int LCD_SETUP_CYC  = 3;
    localparam int LCD_E_HIGH_CYC = 15;
    localparam int LCD_E_LOW_CYC  = 15;
    localparam int LCD_MAX_POLLS  = 255;
    localparam int LCD_BF_BIT     = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_E_HIGH = 3'd2,
        ST_E_LOW  = 3'd3,
        ST_DONE   = 3'd4
    } lcd_rd_state_t;

    function automatic int lcd_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_phase_timer
// Description : Loadable down-counter; done is high in the last cycle of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            cnt_d = load_val;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done = run_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_status_reader.sv
`default_nettype none
// ============================================================================
// Module      : lcd_status_reader
// Description : HD44780 instruction-register reader returning busy flag and
//               address counter, with optional poll-until-ready.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_status_reader
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC  = LCD_SETUP_CYC,
    parameter int E_HIGH_CYC = LCD_E_HIGH_CYC,
    parameter int E_LOW_CYC  = LCD_E_LOW_CYC,
    parameter int MAX_POLLS  = LCD_MAX_POLLS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       wait_ready,
    input  logic [7:0] lcd_db_in,
    output logic       lcd_RS,
    output logic       lcd_RW,
    output logic       lcd_E,
    output logic       bus_own,
    output logic       rd_ack,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       timeout
);

    localparam int TW = $clog2(lcd_max3(SETUP_CYC, E_HIGH_CYC, E_LOW_CYC) + 1);

    localparam logic [TW-1:0] c_setup_ld  = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] c_high_ld   = TW'(E_HIGH_CYC - 1);
    localparam logic [TW-1:0] c_low_ld    = TW'(E_LOW_CYC - 1);
    localparam logic [7:0]    c_max_polls = 8'(MAX_POLLS);

    lcd_rd_state_t state_q, state_d;
    logic          wait_q, wait_d;
    logic [7:0]    polls_q, polls_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic [6:0]    addr_q, addr_d;
    logic          e_q, e_d;
    logic          own_q, own_d;
    logic          ack_q, ack_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    lcd_phase_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        polls_d   = polls_q;
        timeout_d = timeout_q;
        busy_d    = busy_q;
        addr_d    = addr_q;
        tmr_load  = 1'b0;
        tmr_val   = c_setup_ld;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d   = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = c_setup_ld;
                    wait_d    = wait_ready;
                    polls_d   = 8'd0;
                    timeout_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_E_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = c_high_ld;
                end
            end
            ST_E_HIGH: begin
                // Sample on the edge closing the last E-high cycle, E still high.
                if (tmr_done) begin
                    state_d  = ST_E_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = c_low_ld;
                    busy_d   = lcd_db_in[LCD_BF_BIT];
                    addr_d   = lcd_db_in[LCD_BF_BIT-1:0];
                    polls_d  = polls_q + 8'd1;
                end
            end
            ST_E_LOW: begin
                if (tmr_done) begin
                    if (wait_q && busy_q) begin
                        if (polls_q < c_max_polls) begin
                            state_d  = ST_SETUP;
                            tmr_load = 1'b1;
                            tmr_val  = c_setup_ld;
                        end else begin
                            timeout_d = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin outputs are decoded from the next state so they are glitch-free flops.
    always_comb begin
        e_d   = (state_d == ST_E_HIGH);
        own_d = (state_d != ST_IDLE);
        ack_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= 1'b0;
            polls_q   <= 8'd0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= 7'd0;
            e_q       <= 1'b0;
            own_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            polls_q   <= polls_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            e_q       <= e_d;
            own_q     <= own_d;
            ack_q     <= ack_d;
        end
    end

    assign lcd_RS    = 1'b0;
    assign lcd_RW    = own_q;
    assign lcd_E     = e_q;
    assign bus_own   = own_q;
    assign rd_ack    = ack_q;
    assign busy_flag = busy_q;
    assign addr_cnt  = addr_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_status_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_status_reader
// Description : Self-checking bench for lcd_status_reader against a poll-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_status_reader;

    localparam int S    = 3;
    localparam int H    = 15;
    localparam int L    = 15;
    localparam int MAXP = 4;
    localparam int P    = S + H + L;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       rd_req     = 1'b0;
    logic       wait_ready = 1'b0;
    logic [7:0] db         = 8'h00;
    logic       lcd_RS, lcd_RW, lcd_E, bus_own, rd_ack, busy_flag, timeout;
    logic [6:0] addr_cnt;

    lcd_status_reader #(
        .SETUP_CYC  (S),
        .E_HIGH_CYC (H),
        .E_LOW_CYC  (L),
        .MAX_POLLS  (MAXP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .wait_ready (wait_ready),
        .lcd_db_in  (db),
        .lcd_RS     (lcd_RS),
        .lcd_RW     (lcd_RW),
        .lcd_E      (lcd_E),
        .bus_own    (bus_own),
        .rd_ack     (rd_ack),
        .busy_flag  (busy_flag),
        .addr_cnt   (addr_cnt),
        .timeout    (timeout)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Value the LCD presents on DB for each successive poll; the last entry repeats.
    logic [7:0] seq [0:7];
    int         seq_len = 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] seq_at(input int i);
        return seq[(i < seq_len) ? i : seq_len - 1];
    endfunction

    function automatic int model_polls(input bit wr);
        int         n;
        logic [7:0] v;
        n = 1;
        if (wr) begin
            v = seq_at(0);
            while (n < MAXP && v[7]) begin
                n++;
                v = seq_at(n - 1);
            end
        end
        return n;
    endfunction

    // {E, bus_own, rd_ack} expected c cycles after the accepting edge.
    function automatic logic [2:0] model_pins(input int c, input int n);
        logic e;
        if (c < 1) return 3'b000;
        e = 1'b0;
        for (int i = 0; i < n; i++)
            if (c >= i * P + S + 1 && c <= i * P + S + H) e = 1'b1;
        return {e, c <= n * P + 1, c == n * P + 1};
    endfunction

    function automatic logic [13:0] all_outs();
        return {lcd_E, lcd_RW, lcd_RS, bus_own, rd_ack, busy_flag, addr_cnt, timeout};
    endfunction

    task automatic check_pins(input string tag, input int c, input logic [2:0] ep);
        check_eq($sformatf("%s pins c=%0d", tag, c),
                 32'({lcd_E, bus_own, rd_ack, lcd_RW, lcd_RS}),
                 32'({ep, ep[1], 1'b0}));
    endtask

    task automatic check_result(input string tag, input logic [7:0] v, input logic tmo);
        check_eq({tag, " busy"},    32'(busy_flag), 32'(v[7]));
        check_eq({tag, " addr"},    32'(addr_cnt),  32'(v[6:0]));
        check_eq({tag, " timeout"}, 32'(timeout),   32'(tmo));
    endtask

    task automatic run_txn(input string tag, input bit wr, input bit ign);
        int         n;
        logic [7:0] last;
        logic       tmo;
        n    = model_polls(wr);
        last = seq_at(n - 1);
        tmo  = wr && last[7] && (n == MAXP);
        @(posedge clk); #1;
        rd_req     = 1'b1;
        wait_ready = wr;
        db         = seq_at(0);
        @(posedge clk); #1;
        rd_req     = 1'b0;
        wait_ready = 1'($urandom);
        for (int c = 1; c <= n * P + 3; c++) begin
            db     = seq_at((c - 1) / P);
            rd_req = ign && (c == n * P - 5 || c == n * P + 1);
            @(negedge clk);
            check_pins(tag, c, model_pins(c, n));
            if (c == n * P + 1 || c == n * P + 3)
                check_result($sformatf("%s c=%0d", tag, c), last, tmo);
            if (c < n * P + 3) begin
                @(posedge clk); #1;
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic run_back_to_back();
        logic [2:0] ep;
        @(posedge clk); #1;
        rd_req     = 1'b1;
        wait_ready = 1'b0;
        db         = 8'h33;
        @(posedge clk); #1;
        for (int c = 1; c <= 2 * P + 5; c++) begin
            if (c == P + 3) rd_req = 1'b0;
            db = (c <= P + 1) ? 8'h33 : 8'h5A;
            @(negedge clk);
            ep = model_pins(c, 1) | model_pins(c - (P + 2), 1);
            check_pins("b2b", c, ep);
            if (c == P + 1)     check_result("b2b first",  8'h33, 1'b0);
            if (c == 2 * P + 3) check_result("b2b second", 8'h5A, 1'b0);
            if (c < 2 * P + 5) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic run_reset_mid_strobe();
        seq[0]  = 8'h21;
        seq_len = 1;
        @(posedge clk); #1;
        rd_req     = 1'b1;
        wait_ready = 1'b0;
        db         = seq[0];
        @(posedge clk); #1;
        rd_req = 1'b0;
        repeat (9) @(posedge clk);
        #4;
        check_eq("rst pre E", 32'(lcd_E), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rst async outs", 32'(all_outs()), 32'd0);
        @(negedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst idle outs %0d", i), 32'(all_outs()), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset outs", 32'(all_outs()), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle own", 32'(bus_own), 32'd0);

        seq[0] = 8'h45; seq_len = 1;
        run_txn("single", 1'b0, 1'b0);

        seq[0] = 8'h80; seq[1] = 8'h80; seq[2] = 8'h80; seq[3] = 8'h12; seq_len = 4;
        run_txn("poll", 1'b1, 1'b0);

        seq[0] = 8'hFF; seq_len = 1;
        run_txn("timeout", 1'b1, 1'b0);

        seq[0] = 8'h3C; seq_len = 1;
        run_txn("clear", 1'b0, 1'b0);

        seq[0] = 8'h91; seq_len = 1;
        run_txn("ignored", 1'b0, 1'b1);

        run_back_to_back();

        for (int t = 0; t < 12; t++) begin
            int nb;
            nb = int'($urandom_range(0, 5));
            for (int i = 0; i < nb; i++) seq[i] = 8'h80 | 8'($urandom);
            seq[nb] = 8'($urandom) & 8'h7F;
            seq_len = nb + 1;
            run_txn($sformatf("rand%0d", t), 1'($urandom), 1'($urandom));
        end

        run_reset_mid_strobe();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
